sensor_monitor_ctrl: RTL and testbench
======================================

// Module: sensor_monitor_ctrl
// PURPOSE
//  Periodic sampling controller for the 4-bit sensor array. It samples sensors[3:0] every
//  SAMPLE_DIV clocks and evaluates the sensor error function on each sample.
//  It asserts a sticky alarm only after CONFIRM_CNT consecutive errored samples.
//  The alarm holds until the supervisor acknowledges it; fault_code reports the snapshot that tripped it.
// PARAMETERS
//  SAMPLE_DIV   16  clocks between sensor samples; legal range >= 2
//  CONFIRM_CNT   3  consecutive errored samples required to raise alarm; legal range >= 1
// PORTS
//  clk            in   1  system clock, rising edge
//  n_rst          in   1  asynchronous, active-low reset
//  enable         in   1  monitoring enable, level
//  sensors        in   4  raw sensor vector
//  ack            in   1  alarm acknowledge, one-cycle pulse
//  alarm          out  1  sticky confirmed-fault flag (registered)
//  fault_code     out  4  sensor snapshot captured on the tripping sample (registered)
//  sample_strobe  out  1  one-cycle pulse per sample taken (registered)
//  active         out  1  1 in MONITOR/CONFIRM, else 0 (registered)
// BEHAVIOUR
//  - Reset: one clock; n_rst is asynchronous and active-low.
//    n_rst=0 forces state=IDLE, timer=0, count=0, alarm=0, fault_code=4'b0000,
//    sample_strobe=0 and active=0 immediately, with no clock required. Reset mid-operation
//    (including during ALARM) discards everything.
//  - err(s) = s[0] | (s[1] & (s[2] | s[3])).
//  - Timer: width $clog2(SAMPLE_DIV); counts only in MONITOR/CONFIRM and is held at 0 otherwise.
//    tick = (timer == SAMPLE_DIV-1). On tick the timer wraps to 0.
//    The first tick occurs SAMPLE_DIV cycles after entering MONITOR.
//  - On each tick edge: sensors is sampled, err is evaluated, and sample_strobe=1 in the
//    following cycle. There is no sampling outside MONITOR/CONFIRM.
//  - States:
//    IDLE:    enable=1 -> MONITOR.
//    MONITOR: tick & err -> count=1; go to ALARM if CONFIRM_CNT==1, else to CONFIRM.
//             tick & !err -> stay.
//    CONFIRM: tick & err -> count+1; ALARM when count+1 == CONFIRM_CNT.
//             tick & !err -> MONITOR with count=0.
//    ALARM:   alarm=1 and fault_code frozen; timer and count held at 0.
//             ack=1 -> alarm=0 at the next edge; go to MONITOR if enable=1, else IDLE.
//  - Alarm latency: alarm and fault_code update on the same edge that samples the tripping sensor value.
//  - enable=0 in MONITOR/CONFIRM -> IDLE next edge with timer=0 and count=0.
//    enable=0 has priority over a simultaneous tick.
//    enable=0 in ALARM does not clear the alarm; only ack or reset does.
//  - ack outside ALARM is ignored. ack on the same edge that enters ALARM is ignored,
//    because the decision uses the registered state.
//  - fault_code holds its last value after ack until the next alarm.
//  - count saturates at CONFIRM_CNT and never wraps.
// TESTING (SAMPLE_DIV=4, CONFIRM_CNT=3)
//  1. Hold enable=1, sensors=4'b0110 -> sample_strobe pulses every 4 cycles;
//     alarm=1 and fault_code=4'b0110 on the 3rd tick edge (cycle 12 after MONITOR entry).
//  2. Hold sensors=4'b1100 for 10 ticks -> err=0 every sample; alarm stays 0 and active=1 throughout.
//  3. Drive sensors=4'b0001 for 2 ticks, then 4'b0100 for 1 tick, then 4'b0001 ->
//     no alarm until 3 further consecutive ticks; fault_code=4'b0001.
//  4. In ALARM, pulse ack with sensors=4'b0110 still held -> alarm=0 next edge;
//     alarm re-asserts 12 cycles later. An ack pulse in MONITOR has no effect.
//  5. Drop enable after 2 errored ticks, re-raise it 5 cycles later ->
//     state IDLE with active=0; 3 full new errored ticks are needed for alarm.
//  6. Assert n_rst=0 mid-ALARM between clock edges -> alarm, fault_code and active
//     clear immediately; after release, state is IDLE (or MONITOR if enable=1) and timer=0.

Source files
------------

// File: rtl/sensor_monitor_ctrl_if.sv
// -----------------------------------------------------------------------------
// sensor_monitor_ctrl_if
// Purpose : Bundles the supervisor-facing signals of the sensor monitoring
//           controller.
// Signals :
//   enable        monitoring enable, level (master -> slave)
//   sensors[3:0]  raw sensor vector (master -> slave)
//   ack           alarm acknowledge, one-cycle pulse (master -> slave)
//   alarm         sticky confirmed-fault flag (slave -> master)
//   fault_code    sensor snapshot from the tripping sample (slave -> master)
//   sample_strobe one-cycle pulse per sample taken (slave -> master)
//   active        high while monitoring (slave -> master)
// -----------------------------------------------------------------------------
interface sensor_monitor_ctrl_if;
    logic       enable;
    logic [3:0] sensors;
    logic       ack;
    logic       alarm;
    logic [3:0] fault_code;
    logic       sample_strobe;
    logic       active;

    modport master (
        output enable, sensors, ack,
        input  alarm, fault_code, sample_strobe, active
    );

    modport slave (
        input  enable, sensors, ack,
        output alarm, fault_code, sample_strobe, active
    );
endinterface

// File: rtl/sensor_monitor_ctrl.sv
// -----------------------------------------------------------------------------
// sensor_monitor_ctrl
// Purpose : Periodic sampling controller for a 4-bit sensor array. Samples the
//           sensors every SAMPLE_DIV clocks while monitoring, evaluates the
//           sensor error function and raises a sticky alarm after CONFIRM_CNT
//           consecutive errored samples. The alarm holds until acknowledged.
// Ports   :
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    sensor_monitor_ctrl_if.slave (enable, sensors, ack in;
//          alarm, fault_code, sample_strobe, active out, all registered)
// Parameters:
//   SAMPLE_DIV  clocks between samples (>= 2)
//   CONFIRM_CNT consecutive errored samples needed for alarm (>= 1)
// -----------------------------------------------------------------------------
module sensor_monitor_ctrl #(
    parameter int SAMPLE_DIV  = 16,
    parameter int CONFIRM_CNT = 3
) (
    input  logic                        clk,
    input  logic                        n_rst,
    sensor_monitor_ctrl_if.slave        bus
);

    localparam int TW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(CONFIRM_CNT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(CONFIRM_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MONITOR = 2'd1,
        CONFIRM = 2'd2,
        ALARM   = 2'd3
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [CW-1:0] count_q;
    logic          alarm_q;
    logic [3:0]    fault_code_q;
    logic          strobe_q;
    logic          active_q;

    logic          monitoring;
    logic          tick;
    logic          err;
    logic [CW-1:0] count_inc;

    assign monitoring = (state_q == MONITOR) || (state_q == CONFIRM);
    assign tick       = monitoring && (timer_q == TIMER_MAX);
    assign err        = bus.sensors[0] | (bus.sensors[1] & (bus.sensors[2] | bus.sensors[3]));
    // Saturating increment so the counter can never wrap back below the threshold.
    assign count_inc  = (count_q >= COUNT_MAX) ? COUNT_MAX : count_q + 1'b1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            count_q      <= '0;
            alarm_q      <= 1'b0;
            fault_code_q <= 4'b0000;
            strobe_q     <= 1'b0;
            active_q     <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    count_q <= '0;
                    if (bus.enable) begin
                        state_q  <= MONITOR;
                        active_q <= 1'b1;
                    end
                end

                MONITOR, CONFIRM: begin
                    if (!bus.enable) begin
                        // Dropping enable wins over a coincident tick: no sample is taken.
                        state_q  <= IDLE;
                        timer_q  <= '0;
                        count_q  <= '0;
                        active_q <= 1'b0;
                    end else if (tick) begin
                        timer_q  <= '0;
                        strobe_q <= 1'b1;
                        if (err) begin
                            if (count_inc == COUNT_MAX) begin
                                // Alarm and snapshot land on the same edge that samples the fault.
                                state_q      <= ALARM;
                                count_q      <= '0;
                                alarm_q      <= 1'b1;
                                fault_code_q <= bus.sensors;
                                active_q     <= 1'b0;
                            end else begin
                                state_q <= CONFIRM;
                                count_q <= count_inc;
                            end
                        end else begin
                            state_q <= MONITOR;
                            count_q <= '0;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ALARM: begin
                    timer_q <= '0;
                    count_q <= '0;
                    // Only ack releases the alarm; enable merely picks the exit state.
                    if (bus.ack) begin
                        alarm_q <= 1'b0;
                        if (bus.enable) begin
                            state_q  <= MONITOR;
                            active_q <= 1'b1;
                        end else begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q  <= IDLE;
                    timer_q  <= '0;
                    count_q  <= '0;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alarm         = alarm_q;
    assign bus.fault_code    = fault_code_q;
    assign bus.sample_strobe = strobe_q;
    assign bus.active        = active_q;

endmodule

// File: tb/tb_sensor_monitor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sensor_monitor_ctrl
// Directed bench for sensor_monitor_ctrl with SAMPLE_DIV=4, CONFIRM_CNT=3.
// Inputs change 1 ns after a rising edge; outputs are observed at that point.
// -----------------------------------------------------------------------------
module tb_sensor_monitor_ctrl;

    logic clk;
    logic n_rst;
    int   n_cmp;
    int   n_bad;

    sensor_monitor_ctrl_if bus ();

    sensor_monitor_ctrl #(
        .SAMPLE_DIV (4),
        .CONFIRM_CNT(3)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        n_rst       = 1'b0;
        bus.enable  = 1'b0;
        bus.sensors = 4'b0000;
        bus.ack     = 1'b0;

        // Reset state, before any clock edge
        #3;
        chk1("rst_alarm", bus.alarm, 1'b0);
        chk4("rst_fault", bus.fault_code, 4'b0000);
        chk1("rst_strobe", bus.sample_strobe, 1'b0);
        chk1("rst_active", bus.active, 1'b0);
        step(2);
        n_rst = 1'b1;
        step(2);
        chk1("idle_active", bus.active, 1'b0);

        // 1: error pattern 0110 held -> alarm on the 3rd tick edge (cycle 12)
        bus.enable  = 1'b1;
        bus.sensors = 4'b0110;
        step(1);
        chk1("t1_active_entry", bus.active, 1'b1);
        chk1("t1_strobe_entry", bus.sample_strobe, 1'b0);
        step(3);
        chk1("t1_strobe_c3", bus.sample_strobe, 1'b0);
        step(1);
        chk1("t1_strobe_c4", bus.sample_strobe, 1'b1);
        chk1("t1_alarm_c4", bus.alarm, 1'b0);
        step(1);
        chk1("t1_strobe_c5", bus.sample_strobe, 1'b0);
        step(3);
        chk1("t1_strobe_c8", bus.sample_strobe, 1'b1);
        step(3);
        chk1("t1_alarm_c11", bus.alarm, 1'b0);
        step(1);
        chk1("t1_alarm_c12", bus.alarm, 1'b1);
        chk4("t1_fault_c12", bus.fault_code, 4'b0110);
        chk1("t1_strobe_c12", bus.sample_strobe, 1'b1);
        chk1("t1_active_alarm", bus.active, 1'b0);

        // 4: ack clears alarm; ack in MONITOR ignored; re-alarm 12 cycles later
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk1("t4_alarm_ack", bus.alarm, 1'b0);
        chk1("t4_active_ack", bus.active, 1'b1);
        chk4("t4_fault_hold", bus.fault_code, 4'b0110);
        step(1);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk1("t4_ack_monitor", bus.alarm, 1'b0);
        chk1("t4_active_monitor", bus.active, 1'b1);
        step(2);
        chk1("t4_strobe_c4", bus.sample_strobe, 1'b1);
        step(7);
        chk1("t4_alarm_c11", bus.alarm, 1'b0);
        step(1);
        chk1("t4_alarm_c12", bus.alarm, 1'b1);

        // enable=0 in ALARM keeps the alarm; ack with enable=0 goes to IDLE
        bus.enable = 1'b0;
        step(3);
        chk1("alarm_en0_hold", bus.alarm, 1'b1);
        bus.ack = 1'b1;
        step(1);
        bus.ack = 1'b0;
        chk1("ack_en0_alarm", bus.alarm, 1'b0);
        chk1("ack_en0_active", bus.active, 1'b0);
        chk4("ack_en0_fault", bus.fault_code, 4'b0110);
        step(6);
        chk1("idle_no_strobe", bus.sample_strobe, 1'b0);

        // 2: sensors 1100 (no error) for 10 ticks
        bus.sensors = 4'b1100;
        bus.enable  = 1'b1;
        step(1);
        for (int i = 0; i < 10; i++) begin
            step(3);
            chk1("t2_strobe_off", bus.sample_strobe, 1'b0);
            step(1);
            chk1("t2_strobe", bus.sample_strobe, 1'b1);
            chk1("t2_alarm", bus.alarm, 1'b0);
            chk1("t2_active", bus.active, 1'b1);
        end

        // 3: 0001 x2 ticks, 0100 x1 tick, then 0001 -> 3 more ticks needed
        bus.sensors = 4'b0001;
        step(8);
        chk1("t3_alarm_2err", bus.alarm, 1'b0);
        bus.sensors = 4'b0100;
        step(4);
        chk1("t3_alarm_clean", bus.alarm, 1'b0);
        chk1("t3_strobe_clean", bus.sample_strobe, 1'b1);
        bus.sensors = 4'b0001;
        step(8);
        chk1("t3_alarm_t2", bus.alarm, 1'b0);
        step(3);
        chk1("t3_alarm_pre", bus.alarm, 1'b0);
        step(1);
        chk1("t3_alarm", bus.alarm, 1'b1);
        chk4("t3_fault", bus.fault_code, 4'b0001);

        // 5: drop enable after 2 errored ticks, re-raise 5 cycles later
        bus.ack = 1'b1;
        step(1);
        bus.ack     = 1'b0;
        bus.sensors = 4'b0110;
        step(8);
        chk1("t5_alarm_2err", bus.alarm, 1'b0);
        bus.enable = 1'b0;
        step(1);
        chk1("t5_active_off", bus.active, 1'b0);
        step(4);
        chk1("t5_strobe_idle", bus.sample_strobe, 1'b0);
        bus.enable = 1'b1;
        step(1);
        chk1("t5_active_on", bus.active, 1'b1);
        step(4);
        chk1("t5_alarm_t1", bus.alarm, 1'b0);
        chk1("t5_strobe_t1", bus.sample_strobe, 1'b1);
        step(7);
        chk1("t5_alarm_c11", bus.alarm, 1'b0);
        step(1);
        chk1("t5_alarm_c12", bus.alarm, 1'b1);

        // 6: asynchronous reset mid-ALARM, between edges
        #3;
        n_rst = 1'b0;
        #1;
        chk1("t6_alarm_async", bus.alarm, 1'b0);
        chk4("t6_fault_async", bus.fault_code, 4'b0000);
        chk1("t6_active_async", bus.active, 1'b0);
        chk1("t6_strobe_async", bus.sample_strobe, 1'b0);
        step(1);
        chk1("t6_active_held", bus.active, 1'b0);
        n_rst = 1'b1;
        step(1);
        chk1("t6_active_rel", bus.active, 1'b1);
        chk1("t6_alarm_rel", bus.alarm, 1'b0);
        step(4);
        chk1("t6_strobe_c4", bus.sample_strobe, 1'b1);
        step(7);
        chk1("t6_alarm_c11", bus.alarm, 1'b0);
        step(1);
        chk1("t6_alarm_c12", bus.alarm, 1'b1);
        chk4("t6_fault_c12", bus.fault_code, 4'b0110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
